// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// pipe_trace_buffer : one FIFO trace entry per newly fetched CPU instruction,
//                     drained over valid/ready; overflow is counted.
// Revision : 1.0
// ============================================================================
module pipe_trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instruction_i,
  input  logic [31:0]              data_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [95:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
  output logic                     armed
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic [31:0]   prev_pc;
  logic          disarm;

  logic          capture;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign armed     = capture_en && !disarm;
  assign full      = (cnt == FULL_CNT);
  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 96'd0;
  assign count     = cnt;

  // A pc equal to the previous cycle's is a stall repeat; pc 0 is a bubble.
  assign capture = armed && (pc_i != 32'd0) && (pc_i != prev_pc) && !clear;
  assign pop     = out_valid && out_ready && !clear;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pc_i, instruction_i, data_i};
    end
  end

  always_ff @(posedge clk) begin
    prev_pc <= rst ? 32'd0 : pc_i;
    if (rst || clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      disarm   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
      if (drop) begin
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
        overflow <= 1'b1;
        if (STOP_ON_FULL != 0) begin
          disarm <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buffer.sv
`default_nettype none
// Testbench for pipe_trace_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pipe_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, capture_en, clear, out_ready;
  logic [31:0] pc_i, instruction_i, data_i;
  logic        out_valid, overflow, armed;
  logic [95:0] out_data;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
  logic        b_out_valid, b_overflow, b_armed;
  logic [95:0] b_out_data;
  logic [2:0]  b_count;
  logic [15:0] b_drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [95:0] mq[$];
  logic [95:0] popped[$];
  int          m_drops;
  bit          m_ovf;
  logic [31:0] m_prev;

  pipe_trace_buffer #(.DEPTH(16), .CNT_W(16), .STOP_ON_FULL(0)) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .clear(clear),
    .pc_i(pc_i), .instruction_i(instruction_i), .data_i(data_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .drop_cnt(drop_cnt), .overflow(overflow), .armed(armed));

  pipe_trace_buffer #(.DEPTH(4), .CNT_W(16), .STOP_ON_FULL(1)) dut_stop (
    .clk(clk), .rst(rst), .capture_en(capture_en), .clear(clear),
    .pc_i(pc_i), .instruction_i(instruction_i), .data_i(data_i),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .count(b_count), .drop_cnt(b_drop_cnt), .overflow(b_overflow), .armed(b_armed));

  always #5 clk = ~clk;

  // Reference model of the 16-deep instance: FIFO as a queue, rules applied per cycle.
  task automatic model_step();
    bit do_pop;
    bit do_push;
    if (!rst && !clear && out_valid && out_ready) popped.push_back(out_data);
    if (rst || clear) begin
      mq.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      do_pop  = (mq.size() > 0) && out_ready;
      do_push = capture_en && (pc_i != 32'd0) && (pc_i != m_prev);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < DEPTH) mq.push_back({pc_i, instruction_i, data_i});
        else begin
          if (m_drops < 65535) m_drops++;
          m_ovf = 1'b1;
        end
      end
    end
    m_prev = rst ? 32'd0 : pc_i;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] pc);
    pc_i          = pc;
    instruction_i = $urandom;
    data_i        = $urandom;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; capture_en = 1'b0; out_ready = 1'b0;
    pc_i = 32'd0; instruction_i = 32'd0; data_i = 32'd0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", out_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
    checks++; if (out_data !== 96'd0) begin errors++; $display("FAIL reset_data got %h expected 0", out_data); end
    checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_drop got %0d/%b expected 0/0", drop_cnt, overflow); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed_off got %b expected 0", armed); end
    rst = 1'b0;
    capture_en = 1'b1;
    #1;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL reset_armed_on got %b expected 1", armed); end
  endtask

  task automatic test_basic();
    logic [31:0] d1;
    d1 = 32'd0;
    popped.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc_i = 32'(4 * k);
      instruction_i = 32'h2008_0001 + 32'(k);
      data_i = $urandom;
      if (k == 1) d1 = data_i;
      tick();
      if (k == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble_valid got %b expected 0", out_valid); end
      end
      if (k == 1) begin
        checks++; if (out_valid !== 1'b1 || out_data !== {32'h4, 32'h2008_0002, d1}) begin
          errors++; $display("FAIL basic_first got %b/%h expected 1/%h", out_valid, out_data, {32'h4, 32'h2008_0002, d1}); end
      end
    end
    for (int k = 0; k < 3; k++) feed(32'd0);
    checks++; if (popped.size() != 3) begin errors++; $display("FAIL basic_num got %0d expected 3", popped.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (popped[i][95:64] !== 32'(4 * (i + 1)) || popped[i][63:32] !== 32'h2008_0002 + 32'(i)) begin
          errors++; $display("FAIL basic_order[%0d] got %h expected pc %h", i, popped[i], 4 * (i + 1)); end
      end
    end
  endtask

  task automatic test_stall();
    int peak;
    logic [31:0] seq [5];
    seq = '{32'h10, 32'h10, 32'h10, 32'h0, 32'h10};
    peak = 0;
    out_ready = 1'b0;
    popped.delete();
    for (int k = 0; k < 5; k++) begin
      feed(seq[k]);
      if (int'(count) > peak) peak = int'(count);
    end
    checks++; if (count !== 5'd2 || peak != 2) begin
      errors++; $display("FAIL stall_count got %0d peak %0d expected 2", count, peak); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) feed(32'd0);
    checks++; if (popped.size() != 2 || popped[0][95:64] !== 32'h10 || popped[1][95:64] !== 32'h10) begin
      errors++; $display("FAIL stall_entries got %0d entries expected two with pc 10", popped.size()); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    popped.delete();
    for (int k = 0; k < 20; k++) feed(32'h1000 + 32'(4 * k));
    checks++; if (count !== 5'd16 || drop_cnt !== 16'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL full_state got %0d/%0d/%b expected 16/4/1", count, drop_cnt, overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) feed(32'd0);
    checks++; if (popped.size() != 16) begin errors++; $display("FAIL full_drain_num got %0d expected 16", popped.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (popped[i][95:64] !== 32'h1000 + 32'(4 * i)) begin
          errors++; $display("FAIL full_order[%0d] got %h expected %h", i, popped[i][95:64], 32'h1000 + 32'(4 * i)); end
      end
    end
  endtask

  task automatic test_full_pop();
    clear = 1'b1;
    feed(32'h9999_0000);
    clear = 1'b0;
    checks++; if (count !== 5'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_state got %0d/%0d/%b/%b expected 0/0/0/0", count, drop_cnt, overflow, out_valid); end
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) feed(32'h2000 + 32'(4 * k));
    popped.delete();
    out_ready = 1'b1;
    feed(32'h3000);
    checks++; if (count !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL fullpop_state got %0d/%0d/%b expected 16/0/0", count, drop_cnt, overflow); end
    for (int k = 0; k < 17; k++) feed(32'd0);
    checks++; if (popped.size() != 17 || popped[0][95:64] !== 32'h2000 || popped[16][95:64] !== 32'h3000) begin
      errors++; $display("FAIL fullpop_last got %0d entries expected 17 ending pc 3000", popped.size()); end
  endtask

  task automatic test_stop_on_full();
    rst = 1'b1;
    feed(32'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) feed(32'h4000 + 32'(4 * k));
    checks++; if (b_count !== 3'd4 || b_drop_cnt !== 16'd1 || b_overflow !== 1'b1 || b_armed !== 1'b0) begin
      errors++; $display("FAIL stop_disarm got %0d/%0d/%b/%b expected 4/1/1/0", b_count, b_drop_cnt, b_overflow, b_armed); end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) feed(32'h5000 + 32'(4 * k));
    checks++; if (b_count !== 3'd2 || b_drop_cnt !== 16'd1 || b_out_data[95:64] !== 32'h4008) begin
      errors++; $display("FAIL stop_nocapture got %0d/%0d/%h expected 2/1/4008", b_count, b_drop_cnt, b_out_data[95:64]); end
    out_ready = 1'b0;
    clear = 1'b1;
    feed(32'h6000);
    clear = 1'b0;
    checks++; if (b_count !== 3'd0 || b_drop_cnt !== 16'd0 || b_overflow !== 1'b0 || b_armed !== 1'b1) begin
      errors++; $display("FAIL stop_clear got %0d/%0d/%b/%b expected 0/0/0/1", b_count, b_drop_cnt, b_overflow, b_armed); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) feed(32'h7000 + 32'(4 * k));
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_fill got %0d expected 5", count); end
    rst = 1'b1;
    feed(32'h8000);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 5'd0 || out_data !== 96'd0) begin
      errors++; $display("FAIL mid_reset got %b/%0d/%h expected 0/0/0", out_valid, count, out_data); end
    feed(32'h8000);
    checks++; if (count !== 5'd1 || out_data[95:64] !== 32'h8000) begin
      errors++; $display("FAIL mid_recapture got %0d/%h expected 1/8000", count, out_data[95:64]); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'd0;
    clear = 1'b1;
    feed(32'd0);
    clear = 1'b0;
    for (int i = 0; i < 600; i++) begin
      clear      = ($urandom_range(0, 59) == 0);
      capture_en = ($urandom_range(0, 7) != 0);
      out_ready  = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       pc = 32'd0;
        1:       pc = pc;
        default: pc = 32'($urandom_range(1, 40) * 4);
      endcase
      feed(pc);
      checks++; if (count !== 5'(mq.size()) || out_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rand_count[%0d] got %0d/%b expected %0d", i, count, out_valid, mq.size()); end
      checks++; if (out_data !== ((mq.size() > 0) ? mq[0] : 96'd0)) begin
        errors++; $display("FAIL rand_data[%0d] got %h expected %h", i, out_data, (mq.size() > 0) ? mq[0] : 96'd0); end
      checks++; if (drop_cnt !== 16'(m_drops) || overflow !== m_ovf || armed !== capture_en) begin
        errors++; $display("FAIL rand_status[%0d] got %0d/%b/%b expected %0d/%b/%b",
                           i, drop_cnt, overflow, armed, m_drops, m_ovf, capture_en); end
    end
    clear = 1'b0;
  endtask

  initial begin
    m_drops = 0;
    m_ovf   = 1'b0;
    m_prev  = 32'd0;
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_full_pop();
    test_stop_on_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Downstream observer of the pipelined CPU top level. It consumes the CPU's per-cycle pc, fetched-instruction and reg28 outputs, and records one trace entry per newly fetched instruction.
- Entries are held in a FIFO and drained over a valid/ready stream to a debug sink (UART bridge or logic-analyser core).
- Overflow is counted, never silently lost.

Parameters:
DEPTH, 16, number of FIFO entries; power of two, minimum 2
CNT_W, 16, width of the saturating drop counter
STOP_ON_FULL, 0, when 1 capture disarms permanently on the first drop until cleared

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
capture_en  input  1  arm capture; no entries recorded while low
clear  input  1  synchronous flush: empties FIFO, zeroes drop counter and overflow, re-arms
pc_i  input  32  CPU pc output; 0 marks a redirect/bubble slot
instruction_i  input  32  CPU fetched instruction
data_i  input  32  CPU reg28 value
out_valid  output  1  head entry available
out_ready  input  1  sink accepts head entry
out_data  output  96  {pc[95:64], instruction[63:32], data[31:0]} of head entry
count  output  $clog2(DEPTH)+1  current number of stored entries
drop_cnt  output  CNT_W  entries dropped since reset/clear, saturates at all-ones
overflow  output  1  sticky, set on first drop
armed  output  1  capture currently allowed (capture_en and not disarmed)

Behaviour:
- Reset (rst=1 at clk edge): FIFO empty, count=0, out_valid=0, out_data=0, drop_cnt=0, overflow=0, prev_pc=0, disarm flag=0. armed then reflects capture_en.
- prev_pc register: holds pc_i of the previous cycle, updated every cycle including cycles with pc_i=0.
- Capture condition (cycle N): armed && pc_i!=0 && pc_i!=prev_pc. This records each new fetch once, filters pipeline stall repeats and bubble slots, and still records a re-fetch of the same pc after a bubble.
- Entry contents: {pc_i, instruction_i, data_i} sampled in cycle N.
- Push and pop timing: push writes at edge N. out_valid=1 and out_data=entry from cycle N+1, when the FIFO was empty. Pop occurs at an edge where out_valid && out_ready.
- Push when full:
  - If a pop happens in the same cycle, both proceed; count unchanged.
  - Otherwise the entry is dropped: drop_cnt+1 (saturating), overflow<=1. If STOP_ON_FULL=1, the disarm flag is set.
- Simultaneous push and pop when empty: no bypass; the push lands and the pop is ignored (out_valid was 0).
- count = pushes minus pops; range 0..DEPTH. Read and write pointers wrap modulo DEPTH; full/empty are decided by count, not by pointer equality.
- out_data is stable while out_valid && !out_ready. Sink stalls never corrupt the head entry.
- clear has priority over push and pop in the same cycle; the capture condition in that cycle is ignored. prev_pc still updates.
- rst has priority over clear. Reset mid-drain discards all entries; out_valid falls at the reset edge.
- Disarm flag is cleared only by rst or clear. armed = capture_en && !disarm.

Test Plan:
- Basic capture: after reset, capture_en=1, pc_i sequence 0x0,0x4,0x8,0xC with instruction_i=0x20080001+k and out_ready=1 -> three entries out in order. First entry {0x4,0x20080002,data}; out_valid first rises the cycle after pc=0x4.
- Stall filter: pc_i held at 0x10 for 3 cycles, then 0, then 0x10 again -> exactly two entries with pc=0x10; count peaks at 2 with out_ready=0.
- Backpressure and full: DEPTH=16, out_ready=0, 20 distinct pcs -> count=16, drop_cnt=4, overflow=1. The first 16 pcs drain in order once out_ready=1.
- Full with simultaneous pop: FIFO full, out_ready=1 and a new pc in the same cycle -> count stays 16, drop_cnt unchanged, new pc appears as the last entry.
- STOP_ON_FULL=1: overflow by one entry -> armed=0, later pcs not captured. Pulsing clear -> count=0, drop_cnt=0, overflow=0, armed=1.
- Reset mid-operation: 5 entries stored, rst=1 for one cycle -> out_valid=0, count=0, out_data=0 next cycle. The next new pc is captured normally.
